compare_checker: RTL
====================

COMPARE_CHECKER -- requirements
Module: compare_checker

Interface
REQ-001 Parameter: CNT_W, default 8, width of the pass and fail counters.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: reset_L  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  leave IDLE and begin accepting vectors.
REQ-005 Port: clear  input  1  synchronous clear of counters, capture and state.
REQ-006 Port: vec_valid  input  1  stimulus vector and DUT response are present.
REQ-007 Port: vec_ready  output  1  checker accepts a vector this cycle.
REQ-008 Port: a, b, c, d  input  4 each  stimulus operands applied to the DUT.
REQ-009 Port: dut_out  input  1  DUT result for the presented a, b, c, d.
REQ-010 Port: pass_count  output  CNT_W  number of matching vectors.
REQ-011 Port: fail_count  output  CNT_W  number of mismatching vectors.
REQ-012 Port: mismatch  output  1  one-cycle pulse per failing vector.
REQ-013 Port: first_fail_vec  output  16  {a,b,c,d} of the first failing vector.
REQ-014 Port: first_fail_out  output  1  dut_out of the first failing vector.
REQ-015 Port: first_fail_valid  output  1  first_fail_vec and first_fail_out hold a capture.
REQ-016 Port: state_o  output  2  current state: IDLE=0, RUN=1, HALT=2.

Function
REQ-017 Golden model SHALL be: expected = ({1'b0,a} + {1'b0,b}) < {1'b0,(c - d) mod 16}.
- Sum is 5-bit, with no overflow.
- Difference wraps modulo 16.
- Comparison is unsigned.
REQ-018 The FSM SHALL have these transitions:
- IDLE -> RUN on start.
- RUN -> HALT only as defined in REQ-030.
- Any state -> IDLE on clear.
REQ-019 vec_ready SHALL equal (state==RUN) && !clear, decoded combinationally.
REQ-020 A vector SHALL be accepted on a rising edge where vec_valid && vec_ready; a, b, c, d and dut_out are sampled on that edge.
REQ-021 On acceptance, if dut_out==expected, pass_count SHALL increment; otherwise fail_count SHALL increment.
REQ-022 Counter updates SHALL be visible in the cycle following the acceptance edge (latency 1); throughput is one vector per cycle.
REQ-023 mismatch SHALL be high for exactly the one cycle following each failing acceptance.
REQ-024 On the first failing acceptance only, first_fail_vec, first_fail_out and first_fail_valid=1 SHALL be captured; later failures do not overwrite the capture.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 clear SHALL have priority over every other input:
- Vectors presented in a clear cycle are not accepted.
- Counters, captures and mismatch go to 0 and state goes to IDLE.
REQ-027 start while in RUN or HALT SHALL be ignored.
REQ-028 vec_valid while not in RUN SHALL have no effect.

Reset
REQ-029 While reset_L is 0, asynchronously, every output SHALL be forced as follows:
- state=IDLE and vec_ready=0.
- pass_count=0 and fail_count=0.
- mismatch=0.
- first_fail_vec=0, first_fail_out=0 and first_fail_valid=0.
- Reset mid-RUN discards the in-flight vector.

Configuration
REQ-030 Macro CHECKER_HALT_ON_FAIL_EN SHALL control behaviour after the first failure:
- Defined: the first failing acceptance moves RUN -> HALT. HALT holds vec_ready=0 and all counters frozen until clear.
- Undefined: HALT is unreachable, and RUN continues counting after failures.

Verification
REQ-031 Pass: start, then a=1, b=1, c=4, d=1, dut_out=1 -> next cycle pass_count=1, fail_count=0, mismatch=0.
REQ-032 Fail: a=15, b=1, c=1, d=1, dut_out=1 (expected 0) -> mismatch pulse, fail_count=1, first_fail_vec=16'hF111, first_fail_out=1, first_fail_valid=1.
REQ-033 Wrap: a=0, b=0, c=0, d=1, dut_out=1 (c-d=15, expected 1) -> pass.
- Then a=8, b=8, c=8, d=8, dut_out=0 (16<0 false) -> pass.
REQ-034 Saturation: CNT_W=8, 260 back-to-back passing vectors -> pass_count=255.
REQ-035 Halt and clear:
- With CHECKER_HALT_ON_FAIL_EN defined, a failure followed by held vec_valid -> state_o=2, vec_ready=0, counts unchanged.
- Then clear together with vec_valid -> state_o=0, all counters 0, no vector accepted.
- Without the macro, the same stimulus keeps state_o=1.
REQ-036 Async reset: drop reset_L between clock edges mid-RUN -> all outputs 0 immediately, state_o=0.

Source files
------------

// File: rtl/compare_checker.sv
// Checks a 4-input DUT response against the golden rule (a + b) < (c - d) mod 16.
// Keeps pass/fail counters and captures the first failing vector.
// Define CHECKER_HALT_ON_FAIL_EN to stop accepting vectors after the first failure.
module compare_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic             clear,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [3:0]       c,
  input  logic [3:0]       d,
  input  logic             dut_out,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             mismatch,
  output logic [15:0]      first_fail_vec,
  output logic             first_fail_out,
  output logic             first_fail_valid,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             mismatch_q, mismatch_d;
  logic [15:0]      ff_vec_q, ff_vec_d;
  logic             ff_out_q, ff_out_d;
  logic             ff_valid_q, ff_valid_d;

  logic [4:0] sum;
  logic [3:0] diff;
  logic       expected;
  logic       accept;
  logic       vec_fail;

  // Sum kept 5 bits wide so 15 + 15 never overflows; difference wraps mod 16.
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = c - d;
  assign expected = sum < {1'b0, diff};

  assign vec_ready = (state_q == StRun) && !clear;
  assign accept    = vec_valid && vec_ready;
  assign vec_fail  = accept && (dut_out != expected);

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    mismatch_d = 1'b0;
    ff_vec_d   = ff_vec_q;
    ff_out_d   = ff_out_q;
    ff_valid_d = ff_valid_q;

    if (clear) begin
      state_d    = StIdle;
      pass_d     = '0;
      fail_d     = '0;
      ff_vec_d   = '0;
      ff_out_d   = 1'b0;
      ff_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (start) state_d = StRun;
        StRun: begin
          if (accept && !vec_fail && (pass_q != '1)) pass_d = pass_q + 1'b1;
          if (vec_fail) begin
            mismatch_d = 1'b1;
            if (fail_q != '1) fail_d = fail_q + 1'b1;
            if (!ff_valid_q) begin
              ff_vec_d   = {a, b, c, d};
              ff_out_d   = dut_out;
              ff_valid_d = 1'b1;
            end
`ifdef CHECKER_HALT_ON_FAIL_EN
            state_d = StHalt;
`endif
          end
        end
        StHalt: state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StIdle;
      pass_q     <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_out_q   <= 1'b0;
      ff_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      ff_vec_q   <= ff_vec_d;
      ff_out_q   <= ff_out_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign mismatch         = mismatch_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_out   = ff_out_q;
  assign first_fail_valid = ff_valid_q;
  assign state_o          = state_q;

endmodule
